pe_array_sync_cntl: RTL

Parametrised barrier controller for the PE array. It replaces the fixed single-wire `sys__pe__allSynchronized` broadcast with an armed, masked barrier of configurable width. It collects each PE's `pe__sys__thisSynchronized`, releases all participating PEs with a one-cycle broadcast pulse and counts completed barriers. It sits at `pe_array` level beside the stack-bus and NoC connection logic.

---
 rtl/pe_array_sync_pkg.sv | 15 +
 rtl/pe_array_sync_wdog.sv | 31 +++
 rtl/pe_array_sync_cntl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pe_array_sync_pkg.sv
// pe_array_sync_pkg: shared types and default sizes for the PE-array barrier.
// Holds the 2-bit barrier state encoding and default NUM_PE/EPOCH_W/TIMEOUT_W.
package pe_array_sync_pkg;

  localparam int NUM_PE_DEF    = 64;
  localparam int EPOCH_W_DEF   = 8;
  localparam int TIMEOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } sync_state_e;

endpackage

// File: rtl/pe_array_sync_wdog.sv
// pe_array_sync_wdog: WAIT-cycle counter and timeout compare for the barrier.
// Ports: clk, reset_poweron, clr_i (arm accepted), en_i (in WAIT),
//   limit_i (0 = no limit), hit_o (this WAIT cycle is the last allowed one).
module pe_array_sync_wdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [TIMEOUT_W-1:0] limit_i,
  output logic                 hit_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign hit_o   = en_i && (limit_i != '0) && (cnt_inc == limit_i);

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/pe_array_sync_cntl.sv
// pe_array_sync_cntl: armed, masked barrier for the PE array. Collects each
// PE's thisSynchronized, releases participants with a one-cycle broadcast
// pulse and counts completed barriers in a wrapping epoch.
// Ports: clk, reset_poweron (async, high), cfg__sync__arm/peMask (arm request),
//   pe__sys__thisSynchronized (per-PE level), sys__pe__allSynchronized (pulse),
//   sys__pe__epoch, sync__sys__pending, sync__sys__busy.
// Macro PE_ARRAY_SYNC_TIMEOUT_EN adds cfg__sync__timeout / sync__sys__timeout
//   and the pe_array_sync_wdog watchdog.
module pe_array_sync_cntl
  import pe_array_sync_pkg::*;
#(
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int EPOCH_W   = EPOCH_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_poweron,
  input  logic               cfg__sync__arm,
  input  logic [NUM_PE-1:0]  cfg__sync__peMask,
`ifdef PE_ARRAY_SYNC_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0] cfg__sync__timeout,
  output logic               sync__sys__timeout,
`endif
  input  logic [NUM_PE-1:0]  pe__sys__thisSynchronized,
  output logic               sys__pe__allSynchronized,
  output logic [EPOCH_W-1:0] sys__pe__epoch,
  output logic [NUM_PE-1:0]  sync__sys__pending,
  output logic               sync__sys__busy
);

  sync_state_e        state_q;
  logic [NUM_PE-1:0]  activeMask_q;
  logic [NUM_PE-1:0]  arrived_q;
  logic [EPOCH_W-1:0] epoch_q;

  logic [NUM_PE-1:0]  hits;
  logic [NUM_PE-1:0]  arrived_d;
  logic               all_arrived;
  logic               arm_ok;

  assign hits        = pe__sys__thisSynchronized & activeMask_q;
  assign arrived_d   = arrived_q | hits;
  assign all_arrived = (arrived_d == activeMask_q);
  // Arm is honoured only when no barrier is being collected.
  assign arm_ok      = cfg__sync__arm && (state_q != ST_WAIT);

`ifdef PE_ARRAY_SYNC_TIMEOUT_EN
  logic wdog_hit;
  logic tmo_q;

  pe_array_sync_wdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_wdog (
    .clk          (clk),
    .reset_poweron(reset_poweron),
    .clr_i        (arm_ok),
    .en_i         (state_q == ST_WAIT),
    .limit_i      (cfg__sync__timeout),
    .hit_o        (wdog_hit)
  );

  assign sync__sys__timeout = tmo_q;
`endif

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q      <= ST_IDLE;
      activeMask_q <= '0;
      arrived_q    <= '0;
      epoch_q      <= '0;
`ifdef PE_ARRAY_SYNC_TIMEOUT_EN
      tmo_q        <= 1'b0;
`endif
    end else begin
`ifdef PE_ARRAY_SYNC_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      unique case (state_q)
        ST_WAIT: begin
          arrived_q <= arrived_d;
          if (all_arrived) begin
            state_q <= ST_RELEASE;
            epoch_q <= epoch_q + 1'b1;
`ifdef PE_ARRAY_SYNC_TIMEOUT_EN
          end else if (wdog_hit) begin
            state_q <= ST_IDLE;
            tmo_q   <= 1'b1;
`endif
          end
        end
        ST_IDLE, ST_RELEASE: begin
          if (arm_ok) begin
            activeMask_q <= cfg__sync__peMask;
            arrived_q    <= '0;
            // An empty barrier completes without waiting.
            if (cfg__sync__peMask == '0) begin
              state_q <= ST_RELEASE;
              epoch_q <= epoch_q + 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sys__pe__allSynchronized = (state_q == ST_RELEASE);
  assign sync__sys__busy          = (state_q != ST_IDLE);
  assign sync__sys__pending       = activeMask_q & ~arrived_q;
  assign sys__pe__epoch           = epoch_q;

endmodule
